// File: rtl/hex_window_display.sv
// hex_window_display: latches CHANNELS hex words and shows a DIGITS-wide nibble window of each
// on active-low 7-segment outputs. A debounced button slides the window.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 never blanks).
module hex_window_display #(
   parameter int DATA_W          = 16,
   parameter int DIGITS          = 3,
   parameter int CHANNELS        = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int OFF_W          = (DATA_W / 4 > 1) ? $clog2(DATA_W / 4) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   // in_valid/in_ready: a word set transfers on a rising edge where both are high;
   // in_ready is simply !hold, and in_valid while in_ready is low is dropped, not queued.
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   input  logic                         hold,
   input  logic                         btn,
   output logic [OFF_W-1:0]             win_offset,
   output logic [CHANNELS*DIGITS*7-1:0] seg_out,
   output logic [1:0]                   dbg_state
);

   localparam int NIBBLES = DATA_W / 4;
   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(NIBBLES - DIGITS);
   // The sample that leaves IDLE/HELD is the first of the run, so the counter stops one short.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CNT = 2'd1,
      HELD      = 2'd2,
      REL_CNT   = 2'd3
   } db_state_t;

   db_state_t                   state_q, state_nxt;
   logic [CNT_W-1:0]            cnt_q;
   logic [1:0]                  sync_q;
   logic                        btn_s;
   logic                        advance;
   logic [OFF_W-1:0]            off_q;
   logic [CHANNELS*DATA_W-1:0]  data_q;
   logic [CHANNELS*DIGITS*7-1:0] seg_q, seg_nxt;
   logic [DATA_W-1:0]           word;
   logic [DATA_W-1:0]           upper;
   logic [6:0]                  digit;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      g = 7'h40;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h18;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h27;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
         default: g = 7'h40;
      endcase
      return g;
   endfunction

   assign btn_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], btn};
   end

   // Debounce FSM: state register and counter (counter clears on every state entry)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_nxt != state_q || state_q == IDLE || state_q == HELD) cnt_q <= '0;
         else                                                           cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:      if (btn_s) state_nxt = PRESS_CNT;
         PRESS_CNT: if (!btn_s) state_nxt = IDLE;
                    else if (cnt_q == CNT_LAST) state_nxt = HELD;
         HELD:      if (!btn_s) state_nxt = REL_CNT;
         REL_CNT:   if (btn_s) state_nxt = HELD;
                    else if (cnt_q == CNT_LAST) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      advance = 1'b0;
      if (state_q == PRESS_CNT && btn_s && cnt_q == CNT_LAST) advance = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         off_q  <= '0;
      end else begin
         if (in_valid && in_ready) data_q <= in_data;
         if (advance) off_q <= (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
      end
   end

   always_comb begin
      seg_nxt = '0;
      word    = '0;
      upper   = '0;
      digit   = 7'h40;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int k = 0; k < DIGITS; k++) begin
            word  = data_q[c*DATA_W +: DATA_W];
            upper = word >> (4 * (int'(off_q) + k));
            digit = glyph(upper[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
            // upper holds this nibble and everything above it; all zero means a leading zero
            if (k > 0 && upper == '0) digit = 7'h7F;
`endif
            seg_nxt[(c*DIGITS+k)*7 +: 7] = digit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS*DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            seg_q[i*7 +: 7] <= (i % DIGITS == 0) ? 7'h40 : 7'h7F;
`else
            seg_q[i*7 +: 7] <= 7'h40;
`endif
         end
      end else begin
         seg_q <= seg_nxt;
      end
   end

   assign in_ready   = !hold;
   assign win_offset = off_q;
   assign seg_out    = seg_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_hex_window_display.sv
// Bench for hex_window_display: directed scenarios plus randomized traffic, scored against a
// run-length debounce model and arithmetic nibble/glyph lookup.
module tb_hex_window_display;

  localparam int DATA_W   = 16;
  localparam int DIGITS   = 3;
  localparam int CHANNELS = 2;
  localparam int DEB      = 4;
  localparam int SEG_W    = CHANNELS * DIGITS * 7;
  localparam int OFF_MAX  = DATA_W / 4 - DIGITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              hold = 1'b0;
  logic              btn = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic [1:0]        win_offset;
  logic [SEG_W-1:0]  seg_out;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [SEG_W-1:0] exp_q[$];

  logic [31:0] m_data = '0;
  int          m_off  = 0;
  int          m_run  = 0;
  bit          m_deb  = 1'b0;
  bit [1:0]    m_hist = 2'b00;
  bit          m_s;
  bit          m_pulse;
  logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

  hex_window_display #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .CHANNELS(CHANNELS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold(hold), .btn(btn), .win_offset(win_offset), .seg_out(seg_out), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SEG_W-1:0] model_seg(input logic [31:0] data, input int off);
    logic [SEG_W-1:0] s;
    int unsigned w;
    int unsigned up;
    logic [6:0] g;
    s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < DIGITS; k++) begin
        w  = (data >> (c * DATA_W)) & 32'hFFFF;
        up = w >> (4 * (off + k));
        g  = glyph_tab[up & 15];
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && up == 0) g = 7'h7F;
`endif
        s[(c*DIGITS+k)*7 +: 7] = g;
      end
    end
    return s;
  endfunction

  // reference model: registered display of the pre-edge state, button as run-length debounce
  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back(model_seg(32'h0, 0));
      m_data = '0; m_off = 0; m_run = 0; m_deb = 1'b0; m_hist = 2'b00;
    end else begin
      exp_q.push_back(model_seg(m_data, m_off));
      m_s     = m_hist[1];
      m_hist  = {m_hist[0], btn};
      m_pulse = 1'b0;
      if (m_s != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb   = m_s;
          m_run   = 0;
          m_pulse = m_s;
        end
      end else begin
        m_run = 0;
      end
      if (in_valid && !hold) m_data = in_data;
      if (m_pulse) m_off = (m_off >= OFF_MAX) ? 0 : m_off + 1;
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("seg_out", seg_out, exp_q.pop_front());
      check("win_offset", win_offset, m_off);
      check("in_ready", in_ready, !hold);
    end
  end

  // driver tasks
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    cycle(hi);
    btn = 1'b0;
    cycle(lo);
  endtask

  task automatic capture(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    cycle(1);
    in_valid = 1'b0;
  endtask

  logic [20:0] ch0;
  logic [20:0] ch1;
  bit          found;
  logic [15:0] lo_w, hi_w;

  always_comb begin
    ch0 = seg_out[20:0];
    ch1 = seg_out[41:21];
  end

  initial begin
    rst = 1'b1;
    cycle(3);
`ifdef LEADING_ZERO_BLANK_EN
    check("reset_seg", seg_out, {7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h40});
`else
    check("reset_seg", seg_out, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
`endif
    check("reset_offset", win_offset, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    cycle(1);

    capture({16'h1234, 16'h0ABC});
    cycle(1);
    check("capture_ch0", ch0, {7'h08, 7'h03, 7'h27});
    check("capture_ch1", ch1, {7'h24, 7'h30, 7'h19});

    press(8, 8);
    check("press1_offset", win_offset, 1);
    check("press1_ch1", ch1, {7'h79, 7'h24, 7'h30});
    press(8, 8);
    check("press2_wrap", win_offset, 0);
    press(3, 8);
    check("short_press", win_offset, 0);

    btn = 1'b1; cycle(8);
    btn = 1'b0; cycle(2);
    btn = 1'b1; cycle(6);
    btn = 1'b0; cycle(8);
    check("glitch_single_adv", win_offset, 1);

    hold = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    cycle(4);
    check("hold_ready", in_ready, 1'b0);
    check("hold_ch1", ch1, {7'h79, 7'h24, 7'h30});
    hold = 1'b0; in_valid = 1'b0;
    cycle(1);

    // line the capture up with the edge that carries the advance pulse
    btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_deb == 1'b0 && m_hist[1] == 1'b1 && m_run == DEB - 1) found = 1'b1;
      else cycle(1);
    end
    check("adv_align_found", found, 1'b1);
    capture({16'h12F0, 16'hBEEF});
    cycle(1);
    check("cap_adv_offset", win_offset, 0);
    check("cap_adv_ch0", ch0, {7'h06, 7'h06, 7'h0E});
    check("cap_adv_ch1", ch1, {7'h24, 7'h0E, 7'h40});
    btn = 1'b0;
    cycle(8);

`ifdef LEADING_ZERO_BLANK_EN
    capture({16'h1234, 16'h0005});
    cycle(1);
    check("blank_0005", ch0, {7'h7F, 7'h7F, 7'h12});
    capture({16'h1234, 16'h0000});
    cycle(1);
    check("blank_0000", ch0, {7'h7F, 7'h7F, 7'h40});
`endif

    press(8, 8);
    check("pre_reset_offset", win_offset, 1);
    btn = 1'b1;
    cycle(4);
    check("mid_press_state", dbg_state, 1);
    rst = 1'b1; btn = 1'b0;
    cycle(1);
    rst = 1'b0;
    check("abort_state", dbg_state, 0);
    check("abort_offset", win_offset, 0);
    cycle(10);
    check("abort_no_pulse", win_offset, 0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      hold     = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1);
      lo_w     = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      hi_w     = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      in_data  = {hi_w, lo_w};
      rst      = ($urandom_range(0, 150) == 0);
      cycle(1);
    end
    rst = 1'b0; btn = 1'b0; in_valid = 1'b0; hold = 1'b0;
    cycle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
